// File: rtl/tlk2711_reg_sched_if.sv
// Host write/read channels and the controller register port of the TLK2711 register scheduler.
// The scheduler takes the slave side; the host and register model take the master side.
interface tlk2711_reg_sched_if;
  logic        s_wr_valid;
  logic        s_wr_ready;
  logic [15:0] s_wr_addr;
  logic [63:0] s_wr_data;

  logic        s_rd_valid;
  logic        s_rd_ready;
  logic [15:0] s_rd_addr;
  logic        s_rd_rvalid;
  logic [63:0] s_rd_rdata;

  logic        o_reg_wen;
  logic [15:0] o_reg_waddr;
  logic [63:0] o_reg_wdata;
  logic        o_reg_ren;
  logic [15:0] o_reg_raddr;
  logic [63:0] i_reg_rdata;

  modport slave (
    input  s_wr_valid, s_wr_addr, s_wr_data, s_rd_valid, s_rd_addr, i_reg_rdata,
    output s_wr_ready, s_rd_ready, s_rd_rvalid, s_rd_rdata,
    output o_reg_wen, o_reg_waddr, o_reg_wdata, o_reg_ren, o_reg_raddr
  );

  modport master (
    output s_wr_valid, s_wr_addr, s_wr_data, s_rd_valid, s_rd_addr, i_reg_rdata,
    input  s_wr_ready, s_rd_ready, s_rd_rvalid, s_rd_rdata,
    input  o_reg_wen, o_reg_waddr, o_reg_wdata, o_reg_ren, o_reg_raddr
  );
endinterface

// File: rtl/tlk2711_reg_sched.sv
// Arbitrates interrupt-service reads, host writes and host reads onto the single TLK2711
// register port, snapshots the interrupt status and counts interrupt rising edges.
module tlk2711_reg_sched #(
  parameter logic [15:0] IRQ_ADDR   = 16'h0060,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  tlk2711_reg_sched_if.slave        bus,
  input  logic                      i_tx_irq,
  input  logic                      i_rx_irq,
  input  logic                      i_loss_irq,
  output logic                      o_irq_valid,
  output logic [2:0]                o_irq_src,
  output logic [63:0]               o_irq_status,
  output logic [7:0]                o_tx_irq_cnt,
  output logic [7:0]                o_rx_irq_cnt,
  output logic [7:0]                o_loss_irq_cnt,
  output logic                      o_busy
);

  localparam int unsigned WaitLoad = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
  localparam int unsigned GapLoad  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StRdCap, StGap} state_e;

  state_e      state_q, state_d;
  logic [2:0]  irq_dly_q, pend_q, pend_d, pend_clr, src_q, src_d;
  logic [2:0]  irq_in, irq_rise;
  logic        svc_q, svc_d;
  logic [1:0]  wait_q, wait_d;
  logic [2:0]  gap_q, gap_d;
  logic [15:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        idle, wr_accept, rd_accept;
  logic        irq_valid_q, rvalid_q;
  logic [2:0]  irq_src_q;
  logic [63:0] irq_status_q, rdata_q;
  logic [7:0]  tx_cnt_q, rx_cnt_q, loss_cnt_q;

  always_comb begin
    irq_in   = {i_loss_irq, i_rx_irq, i_tx_irq};
    irq_rise = irq_in & ~irq_dly_q;
    idle     = (state_q == StIdle);
    // Ready is held low during reset so the handshake shows its reset value.
    bus.s_wr_ready = idle && (pend_q == 3'b000) && !rst;
    bus.s_rd_ready = idle && (pend_q == 3'b000) && !bus.s_wr_valid && !rst;
    wr_accept = bus.s_wr_valid && bus.s_wr_ready;
    rd_accept = bus.s_rd_valid && bus.s_rd_ready;
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    svc_d    = svc_q;
    wait_d   = wait_q;
    gap_d    = gap_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    pend_clr = 3'b000;
    case (state_q)
      StIdle: begin
        if (pend_q != 3'b000) begin
          state_d  = StRd;
          raddr_d  = IRQ_ADDR;
          src_d    = pend_q;
          pend_clr = pend_q;
          svc_d    = 1'b1;
        end else if (wr_accept) begin
          state_d = StWr;
          waddr_d = bus.s_wr_addr;
          wdata_d = bus.s_wr_data;
        end else if (rd_accept) begin
          state_d = StRd;
          raddr_d = bus.s_rd_addr;
          svc_d   = 1'b0;
        end
      end
      StRd: begin
        if (RD_LATENCY <= 1) begin
          state_d = StRdCap;
        end else begin
          state_d = StRdWait;
          wait_d  = 2'(WaitLoad);
        end
      end
      StRdWait: begin
        if (wait_q == 2'd0) state_d = StRdCap;
        else                wait_d  = wait_q - 2'd1;
      end
      StWr, StRdCap: begin
        if (GAP_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          gap_d   = 3'(GapLoad);
        end
      end
      StGap: begin
        if (gap_q == 3'd0) state_d = StIdle;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase
    // A rising edge in the same cycle as the clear keeps its pend bit.
    pend_d = (pend_q & ~pend_clr) | irq_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      irq_dly_q    <= 3'b000;
      pend_q       <= 3'b000;
      src_q        <= 3'b000;
      svc_q        <= 1'b0;
      wait_q       <= 2'd0;
      gap_q        <= 3'd0;
      waddr_q      <= 16'h0;
      wdata_q      <= 64'h0;
      raddr_q      <= 16'h0;
      irq_valid_q  <= 1'b0;
      irq_src_q    <= 3'b000;
      irq_status_q <= 64'h0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 64'h0;
      tx_cnt_q     <= 8'h0;
      rx_cnt_q     <= 8'h0;
      loss_cnt_q   <= 8'h0;
    end else begin
      state_q     <= state_d;
      irq_dly_q   <= irq_in;
      pend_q      <= pend_d;
      src_q       <= src_d;
      svc_q       <= svc_d;
      wait_q      <= wait_d;
      gap_q       <= gap_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      irq_valid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      if (state_q == StRdCap) begin
        if (svc_q) begin
          irq_valid_q  <= 1'b1;
          irq_src_q    <= src_q;
          irq_status_q <= bus.i_reg_rdata;
        end else begin
          rvalid_q <= 1'b1;
          rdata_q  <= bus.i_reg_rdata;
        end
      end
      if (irq_rise[0]) tx_cnt_q   <= tx_cnt_q + 8'd1;
      if (irq_rise[1]) rx_cnt_q   <= rx_cnt_q + 8'd1;
      if (irq_rise[2]) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  always_comb begin
    bus.o_reg_wen   = (state_q == StWr);
    bus.o_reg_ren   = (state_q == StRd);
    bus.o_reg_waddr = waddr_q;
    bus.o_reg_wdata = wdata_q;
    bus.o_reg_raddr = raddr_q;
    bus.s_rd_rvalid = rvalid_q;
    bus.s_rd_rdata  = rdata_q;
    o_irq_valid     = irq_valid_q;
    o_irq_src       = irq_src_q;
    o_irq_status    = irq_status_q;
    o_tx_irq_cnt    = tx_cnt_q;
    o_rx_irq_cnt    = rx_cnt_q;
    o_loss_irq_cnt  = loss_cnt_q;
    o_busy          = !idle;
  end

endmodule

// File: tb/tb_tlk2711_reg_sched.sv
// Scoreboard bench for tlk2711_reg_sched: directed stimulus pushes expected register-port
// strobes and result pulses; a negedge monitor pops and compares them.
module tb_tlk2711_reg_sched;
  localparam logic [15:0] IrqAddr   = 16'h0060;
  localparam int unsigned RdLat     = 2;
  localparam int unsigned GapCycles = 1;
  localparam logic [63:0] IrqStatus = 64'h0000_0000_0000_0C0D;

  logic        clk;
  logic        rst;
  logic        tx_irq, rx_irq, loss_irq;
  logic        irq_valid;
  logic [2:0]  irq_src;
  logic [63:0] irq_status;
  logic [7:0]  tx_cnt, rx_cnt, loss_cnt;
  logic        busy;

  tlk2711_reg_sched_if bus ();

  tlk2711_reg_sched #(
    .IRQ_ADDR  (IrqAddr),
    .RD_LATENCY(RdLat),
    .GAP_CYCLES(GapCycles)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .i_tx_irq      (tx_irq),
    .i_rx_irq      (rx_irq),
    .i_loss_irq    (loss_irq),
    .o_irq_valid   (irq_valid),
    .o_irq_src     (irq_src),
    .o_irq_status  (irq_status),
    .o_tx_irq_cnt  (tx_cnt),
    .o_rx_irq_cnt  (rx_cnt),
    .o_loss_irq_cnt(loss_cnt),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } strobe_t;

  typedef struct packed {
    logic [2:0]  src;
    logic [63:0] status;
  } irq_t;

  strobe_t     strobe_q[$];
  logic [63:0] rd_q[$];
  irq_t        irq_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  function automatic logic [63:0] reg_val(input logic [15:0] a);
    case (a)
      16'h0050: return 64'h0000_0000_DEAD_BEEF;
      16'h0060: return IrqStatus;
      default:  return {48'h0, a};
    endcase
  endfunction

  // Register model: data is valid exactly RdLat cycles after the read strobe, junk otherwise.
  logic        p1_v = 1'b0;
  logic [15:0] p1_a = 16'h0;
  always @(posedge clk) begin
    p1_v <= bus.o_reg_ren;
    p1_a <= bus.o_reg_raddr;
    bus.i_reg_rdata <= p1_v ? reg_val(p1_a) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    strobe_t e;
    irq_t    ie;
    logic [63:0] rd;
    if (rst) begin
      prev_strobe <= 1'b0;
    end else begin
      if (bus.o_reg_wen || bus.o_reg_ren) begin
        check("strobe_exclusive", 64'(bus.o_reg_wen & bus.o_reg_ren), 64'h0);
        check("strobe_spacing", 64'(prev_strobe), 64'h0);
        if (strobe_q.size() == 0) begin
          fail_now("strobe_unexpected", $sformatf("wen=%0b ren=%0b", bus.o_reg_wen,
                   bus.o_reg_ren));
        end else begin
          e = strobe_q.pop_front();
          check("strobe_kind", 64'(bus.o_reg_wen), 64'(e.wr));
          check("strobe_addr", 64'(bus.o_reg_wen ? bus.o_reg_waddr : bus.o_reg_raddr),
                64'(e.addr));
          if (e.wr) check("strobe_wdata", bus.o_reg_wdata, e.data);
        end
      end
      prev_strobe <= bus.o_reg_wen || bus.o_reg_ren;
      if (bus.s_rd_rvalid) begin
        if (rd_q.size() == 0) begin
          fail_now("rvalid_unexpected", $sformatf("rdata=%0h", bus.s_rd_rdata));
        end else begin
          rd = rd_q.pop_front();
          check("host_rdata", bus.s_rd_rdata, rd);
        end
      end
      if (irq_valid) begin
        if (irq_q.size() == 0) begin
          fail_now("irq_valid_unexpected", $sformatf("src=%0b", irq_src));
        end else begin
          ie = irq_q.pop_front();
          check("irq_src", 64'(irq_src), 64'(ie.src));
          check("irq_status", irq_status, ie.status);
        end
      end
    end
  end

  task automatic host_write(input logic [15:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    bus.s_wr_valid = 1'b1;
    bus.s_wr_addr  = a;
    bus.s_wr_data  = d;
    #1;
    while (!bus.s_wr_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.s_wr_ready) fail_now("wr_accept_timeout", "no ready");
    @(posedge clk);
    #1;
    bus.s_wr_valid = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a);
    int n = 0;
    @(negedge clk);
    bus.s_rd_valid = 1'b1;
    bus.s_rd_addr  = a;
    #1;
    while (!bus.s_rd_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.s_rd_ready) fail_now("rd_accept_timeout", "no ready");
    @(posedge clk);
    #1;
    bus.s_rd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #2;
      if (!busy && strobe_q.size() == 0 && rd_q.size() == 0 && irq_q.size() == 0) return;
    end
    fail_now(name, "drain timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.o_reg_wen, bus.o_reg_ren, bus.s_wr_ready, bus.s_rd_ready,
                              busy, irq_valid, bus.s_rd_rvalid}), 64'h0);
    check({tag, "_addr"}, 64'({bus.o_reg_waddr, bus.o_reg_raddr}), 64'h0);
    check({tag, "_wdata"}, bus.o_reg_wdata, 64'h0);
    check({tag, "_rdata"}, bus.s_rd_rdata, 64'h0);
    check({tag, "_status"}, irq_status, 64'h0);
    check({tag, "_src_cnt"}, 64'({irq_src, tx_cnt, rx_cnt, loss_cnt}), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    tx_irq = 1'b0;
    rx_irq = 1'b0;
    loss_irq = 1'b0;
    bus.s_wr_valid = 1'b0;
    bus.s_wr_addr  = 16'h0;
    bus.s_wr_data  = 64'h0;
    bus.s_rd_valid = 1'b0;
    bus.s_rd_addr  = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Configuration write; ready must drop for exactly WR + one gap cycle.
    strobe_q.push_back('{wr: 1'b1, addr: 16'h0020, data: 64'h0000_0300_0000_0000});
    host_write(16'h0020, 64'h0000_0300_0000_0000);
    @(negedge clk); check("wr_ready_a1", 64'(bus.s_wr_ready), 64'h0);
    @(negedge clk); check("wr_ready_a2", 64'(bus.s_wr_ready), 64'h0);
    @(negedge clk); check("wr_ready_a3", 64'(bus.s_wr_ready), 64'h1);
    wait_drain("drain_write");

    // Host read with two-cycle register latency.
    strobe_q.push_back('{wr: 1'b0, addr: 16'h0050, data: 64'h0});
    rd_q.push_back(64'h0000_0000_DEAD_BEEF);
    host_read(16'h0050);
    wait_drain("drain_read");

    // TX re-rises during RD_WAIT of its own service: second service with src=001.
    strobe_q.push_back('{wr: 1'b0, addr: IrqAddr, data: 64'h0});
    strobe_q.push_back('{wr: 1'b0, addr: IrqAddr, data: 64'h0});
    irq_q.push_back('{src: 3'b001, status: IrqStatus});
    irq_q.push_back('{src: 3'b001, status: IrqStatus});
    @(negedge clk);
    tx_irq = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!bus.o_reg_ren && n < 20);
      if (!bus.o_reg_ren) fail_now("tx_ren_timeout", "no ren");
    end
    tx_irq = 1'b0;
    @(negedge clk);
    tx_irq = 1'b1;
    wait_drain("drain_tx_rerise");
    check("tx_cnt_rerise", 64'(tx_cnt), 64'd2);
    tx_irq = 1'b0;

    // TX and loss together: one service read reporting both.
    strobe_q.push_back('{wr: 1'b0, addr: IrqAddr, data: 64'h0});
    irq_q.push_back('{src: 3'b101, status: IrqStatus});
    @(negedge clk);
    tx_irq = 1'b1;
    loss_irq = 1'b1;
    wait_drain("drain_tx_loss");
    check("tx_cnt_pair", 64'(tx_cnt), 64'd3);
    check("loss_cnt_pair", 64'(loss_cnt), 64'd1);
    tx_irq = 1'b0;
    loss_irq = 1'b0;

    // RX irq with a host write presented while it is pending: service read goes first.
    strobe_q.push_back('{wr: 1'b0, addr: IrqAddr, data: 64'h0});
    strobe_q.push_back('{wr: 1'b1, addr: 16'h0024, data: 64'h0123_4567_89AB_CDEF});
    irq_q.push_back('{src: 3'b010, status: IrqStatus});
    @(negedge clk);
    rx_irq = 1'b1;
    host_write(16'h0024, 64'h0123_4567_89AB_CDEF);
    wait_drain("drain_rx_write");
    check("rx_cnt", 64'(rx_cnt), 64'd1);
    rx_irq = 1'b0;

    // Reset during RD_WAIT: read abandoned, no result pulse, everything back to zero.
    strobe_q.push_back('{wr: 1'b0, addr: 16'h0050, data: 64'h0});
    host_read(16'h0050);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    strobe_q.push_back('{wr: 1'b1, addr: 16'h0030, data: 64'h1122_3344_5566_7788});
    host_write(16'h0030, 64'h1122_3344_5566_7788);
    wait_drain("drain_post_reset");

    check("queues_empty", 64'(strobe_q.size() + rd_q.size() + irq_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tlk2711_reg_sched.md
# tlk2711_reg_sched

Register-port scheduler in front of the TLK2711 controller's single register interface (`wen/waddr/wdata`, `ren/raddr/rdata`). It arbitrates three requesters onto that one port:

- host configuration writes,
- host register reads,
- autonomous interrupt-service reads triggered by the TX, RX and loss interrupt lines.

It snapshots the interrupt status word, reports which sources caused it, and keeps per-source interrupt counters for software and debug.

## Interface
Parameters:
- `IRQ_ADDR`, 16'h0060: register offset read on interrupt service.
- `RD_LATENCY`, 1: cycles from `o_reg_ren` high to `i_reg_rdata` valid; legal range 1–4.
- `GAP_CYCLES`, 1: idle cycles forced on the register port after every access; legal range 0–7.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `s_wr_valid`, in, 1: host write request.
- `s_wr_ready`, out, 1: write accepted when `valid & ready`.
- `s_wr_addr`, in, 16: write offset.
- `s_wr_data`, in, 64: write data.
- `s_rd_valid`, in, 1: host read request.
- `s_rd_ready`, out, 1: read accepted when `valid & ready`.
- `s_rd_addr`, in, 16: read offset.
- `s_rd_rvalid`, out, 1: one-cycle pulse; `s_rd_rdata` valid.
- `s_rd_rdata`, out, 64: host read result.
- `i_tx_irq`, in, 1: level interrupt from the controller.
- `i_rx_irq`, in, 1: level interrupt from the controller.
- `i_loss_irq`, in, 1: level interrupt from the controller.
- `o_reg_wen`, out, 1: register write strobe.
- `o_reg_waddr`, out, 16: register write address.
- `o_reg_wdata`, out, 64: register write data.
- `o_reg_ren`, out, 1: register read strobe.
- `o_reg_raddr`, out, 16: register read address.
- `i_reg_rdata`, in, 64: register read data.
- `o_irq_valid`, out, 1: one-cycle pulse; status snapshot ready.
- `o_irq_src`, out, 3: sources serviced; {loss, rx, tx}.
- `o_irq_status`, out, 64: data read from `IRQ_ADDR`.
- `o_tx_irq_cnt`, out, 8: TX rising-edge count.
- `o_rx_irq_cnt`, out, 8: RX rising-edge count.
- `o_loss_irq_cnt`, out, 8: loss rising-edge count.
- `o_busy`, out, 1: high in any state other than IDLE.

## Operation
- Edge detect: each irq input is registered; `irq & ~irq_d` sets that source's `pend` bit and increments its counter, mod 256 (wraps 255→0).
- States: IDLE, WR, RD, RD_WAIT, RD_CAP, GAP.
- Arbitration is evaluated only in IDLE, fixed priority: `pend != 0`, then host write, then host read.
- IRQ service: IDLE→RD with `o_reg_raddr = IRQ_ADDR`; the pend snapshot is latched as `src_q` and those bits are cleared.
- Host write: `s_wr_ready` is high in IDLE when `pend == 0`. Acceptance latches addr/data and goes to WR.
- Host read: `s_rd_ready` is high in IDLE when `pend == 0` and `!s_wr_valid`. Acceptance latches the address and goes to RD.
- WR: `o_reg_wen = 1` for one cycle, then GAP.
- RD: `o_reg_ren = 1` for one cycle, then RD_WAIT.
- RD_WAIT: counts `RD_LATENCY-1` cycles; this is 0 cycles when `RD_LATENCY = 1`. Then RD_CAP.
- RD_CAP: samples `i_reg_rdata`. IRQ read: pulses `o_irq_valid` with `o_irq_src = src_q` and `o_irq_status` = data. Host read: pulses `s_rd_rvalid` with `s_rd_rdata`. Then GAP.
- GAP: stays `GAP_CYCLES` cycles, then IDLE. With `GAP_CYCLES = 0`, RD_CAP/WR return directly to IDLE.
- A new edge arriving in the same cycle its pend bit is cleared keeps the bit set (set wins). It is serviced by a later read; the counter still increments.
- Edges during a service are never lost: they accumulate in pend.
- Data and address outputs hold their last value when strobes are low.
- Reset mid-operation: the access is abandoned immediately and no result pulse is issued. Pend, `src_q`, counters and `irq_d` clear. The edge detector treats an irq already high at reset release as a new edge in the first cycle after reset.

## Timing
- Reset values: all strobes, `s_*_ready`, `o_busy`, `o_irq_valid`, `s_rd_rvalid` = 0. All addr/data/status/src/counters = 0.
- Irq input at cycle T → pend and counter updated at T+1 → IDLE decision at T+1 → `o_reg_ren` at T+2 (if IDLE).
- Host write accepted at cycle A → `o_reg_wen` at A+1 → next acceptance no earlier than A+2+`GAP_CYCLES`.
- Read strobe at R → data sampled at R+`RD_LATENCY` → result pulse at R+`RD_LATENCY` (registered output visible R+`RD_LATENCY`+1).
- Never more than one of `o_reg_wen` / `o_reg_ren` high; never two strobes in consecutive cycles when `GAP_CYCLES ≥ 1`.

## Test plan
- Write 0x0020←0x0000_0300_0000_0000 (`GAP_CYCLES = 1`) → single `o_reg_wen` pulse with matching addr/data; `s_wr_ready` low for exactly 2 cycles after acceptance.
- Host read of 0x0050, model returning 0xDEAD_BEEF after `RD_LATENCY = 2` → `s_rd_rvalid` pulse with 0xDEAD_BEEF; no `o_irq_valid`.
- `i_rx_irq` rises while a host write is pending in the same cycle → IRQ read of 0x0060 issued first, `o_irq_src = 3'b010`, `o_rx_irq_cnt = 1`; the write follows after the gap.
- `i_tx_irq` and `i_loss_irq` rise together → one service read, `o_irq_src = 3'b101`, both counters = 1.
- `i_tx_irq` re-rises during RD_WAIT of its own service → second service read with `o_irq_src = 3'b001`, `o_tx_irq_cnt = 2`.
- Assert `rst` during RD_WAIT → next cycle all outputs at reset values, no `s_rd_rvalid`, counters 0; a normal write succeeds after release.
